// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared store-path types: size encodings, byte-enable width, lane entry
//
// Provides the st_size encodings, the data and byte-enable widths, and the
// lane-formatted payload carried by every buffered store.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } st_size_e;

    // Lane-formatted payload; the address is added by the owner because its
    // width is a parameter of the owning block.
    typedef struct packed {
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } lane_t;

endpackage

// File: rtl/store_lane_format.sv
// rtl/store_lane_format.sv - combinational SB/SH/SW lane replication and byte enables
//
// Ports:
//   addr       in  2       low byte-address bits of the store
//   size       in  2       st_size_e encoding
//   data       in  32      register value to store
//   wdata      out 32      data replicated into every lane it may land in
//   be         out 4       byte enables, bit i covers wdata[8i+7:8i]
//   misaligned out 1       store must be rejected (bad alignment or illegal size)
module store_lane_format
    import mips_pkg::*;
(
    input  logic [1:0]        addr,
    input  st_size_e          size,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] wdata,
    output logic [BE_W-1:0]   be,
    output logic              misaligned
);

    always_comb begin
        wdata      = '0;
        be         = '0;
        misaligned = 1'b0;
        unique case (size)
            SZ_BYTE: begin
                wdata = {4{data[7:0]}};
                be    = 4'b0001 << addr;
            end
            SZ_HALF: begin
                wdata      = {2{data[15:0]}};
                be         = addr[1] ? 4'b1100 : 4'b0011;
                misaligned = addr[0];
            end
            SZ_WORD: begin
                wdata      = data;
                be         = 4'b1111;
                misaligned = (addr != 2'b00);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_data_aligner.sv
// rtl/store_data_aligner.sv - store lane formatter with DEPTH-entry FIFO toward data memory
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   st_valid/st_ready     store request handshake
//   st_addr, st_data      byte address and rs2 value
//   st_size               00 byte, 01 half, 10 word, 11 illegal
//   mem_valid/mem_ready   head-entry handshake toward data memory
//   mem_addr              word-aligned address of the head entry
//   mem_wdata, mem_be     lane-formatted data and byte enables of the head entry
//   misalign              one-cycle pulse after a store is rejected
//   count                 number of occupied entries
module store_data_aligner
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      st_valid,
    output logic                      st_ready,
    input  logic [ADDR_W-1:0]         st_addr,
    input  logic [DATA_W-1:0]         st_data,
    input  logic [1:0]                st_size,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [BE_W-1:0]           mem_be,
    output logic                      misalign,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        lane_t             lane;
    } entry_t;

    entry_t            fifo [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              misalign_q;

    logic [DATA_W-1:0] fmt_wdata;
    logic [BE_W-1:0]   fmt_be;
    logic              fmt_misaligned;
    entry_t            new_entry;
    logic              accept;
    logic              push;
    logic              pop;

    store_lane_format u_fmt (
        .addr       (st_addr[1:0]),
        .size       (st_size_e'(st_size)),
        .data       (st_data),
        .wdata      (fmt_wdata),
        .be         (fmt_be),
        .misaligned (fmt_misaligned)
    );

    // st_ready looks only at count: a pop in the same cycle does not free a
    // slot for the incoming store, so a full buffer never bypasses.
    assign st_ready  = (count_q != CNT_W'(DEPTH));
    assign mem_valid = (count_q != '0);
    assign accept    = st_valid && st_ready;
    assign push      = accept && !fmt_misaligned;
    assign pop       = mem_valid && mem_ready;

    always_comb begin
        new_entry            = '0;
        new_entry.addr       = {st_addr[ADDR_W-1:2], 2'b00};
        new_entry.lane.wdata = fmt_wdata;
        new_entry.lane.be    = fmt_be;
    end

    // Storage is cleared on reset so the mem_* outputs read zero while
    // rst_n is low, with no clock edge needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo[i] <= '0;
            end
        end else if (push) begin
            fifo[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= accept && fmt_misaligned;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign mem_addr  = fifo[rd_ptr].addr;
    assign mem_wdata = fifo[rd_ptr].lane.wdata;
    assign mem_be    = fifo[rd_ptr].lane.be;
    assign misalign  = misalign_q;
    assign count     = count_q;

endmodule
